pulse_cmd_arbiter: RTL
======================

# pulse_cmd_arbiter

Collects per-channel edge pulses from the front-end edge-detection stage and queues them as pending requests. It issues them one at a time to the single shared downstream command/pulse resource, using round-robin arbitration and a valid/ready handshake. Each granted channel drives a one-hot output pulse of fixed length, followed by a mandatory one-cycle gap. The block sits between the edge detectors and the DIF command/trigger generator, so simultaneous channel edges are never lost or merged.

## Interface
Parameters:
- SIZE, 8, number of request channels
- IDX_W, 3, width of channel index; must satisfy 2**IDX_W >= SIZE
- PULSE_LEN, 4, cycles cmd_pulse is held high per grant; must be >= 1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_pulse  in  SIZE  single-cycle request pulses, one bit per channel
- enable  in  1  permits new grants from IDLE
- cmd_valid  out  1  command offer to downstream resource
- cmd_ready  in  1  downstream accepts command
- cmd_idx  out  IDX_W  index of the granted channel; stable while cmd_valid is high
- cmd_pulse  out  SIZE  one-hot pulse for the granted channel during HOLD
- pending  out  SIZE  latched, not-yet-granted requests
- busy  out  1  high in any state other than IDLE
- ovf_clr  in  1  synchronous clear of ovf_cnt (only with macro)
- ovf_cnt  out  16  saturating overflow count (only with macro)

## Operation
- pending register:
  - Bit i is set on any cycle where req_pulse[i]=1.
  - Bit i is cleared on the grant edge for channel i.
  - If set and clear coincide, set wins and the request is re-queued.
- FSM states: IDLE, ISSUE, HOLD, GAP.
- IDLE:
  - If enable=1 and pending!=0, the FSM selects a winner and moves to ISSUE.
  - On that edge, the winner index is latched into cmd_idx and its pending bit is cleared.
- Round-robin selection:
  - The search starts at (last_grant+1) mod SIZE and wraps around.
  - After reset, last_grant = SIZE-1, so channel 0 has first priority.
  - last_grant updates on each grant.
- ISSUE:
  - cmd_valid=1.
  - On an edge with cmd_ready=1, the FSM moves to HOLD and loads the counter with PULSE_LEN-1.
  - cmd_idx does not change while waiting for cmd_ready.
- HOLD:
  - cmd_pulse = one-hot(cmd_idx).
  - The counter decrements each cycle.
  - At counter 0, the FSM moves to GAP.
- GAP: all outputs inactive for one cycle, then IDLE.
- enable=0:
  - No new grants are issued from IDLE.
  - A grant already in ISSUE/HOLD/GAP runs to completion.
  - pending continues to accumulate.
- Reset values: cmd_valid=0, cmd_idx=0, cmd_pulse=0, pending=0, busy=0, ovf_cnt=0, FSM=IDLE, counter=0.
- Reset asserted mid-operation: everything returns to reset values immediately and all pending requests are discarded.

## Timing
- req_pulse in cycle N sets pending after edge N.
- The earliest cmd_valid is in cycle N+2, i.e. a 2-cycle request-to-offer latency.
- With cmd_ready=1 in the first ISSUE cycle:
  - cmd_pulse is high for cycles N+3 .. N+2+PULSE_LEN.
  - GAP occupies the next cycle.
- Minimum spacing between consecutive grants is PULSE_LEN+3 cycles (ISSUE + PULSE_LEN HOLD + GAP + IDLE).
- cmd_pulse is never high in two consecutive grants without an intervening low cycle.
- busy is registered and matches state != IDLE.

## Configuration
- PULSE_CMD_ARBITER_OVF_EN defined:
  - ovf_cnt increments by 1 in any cycle where req_pulse[i]=1 for some i whose pending bit is already 1 and is not being cleared that cycle.
  - ovf_cnt saturates at 0xFFFF.
  - ovf_clr=1 zeroes ovf_cnt and takes priority over an increment in the same cycle.
- Macro undefined:
  - ovf_cnt is tied to 0 and ovf_clr is ignored.
  - No counter logic is synthesised.

## Test plan
- Single request, SIZE=8, PULSE_LEN=4, cmd_ready=1:
  - req_pulse=0x04 in cycle 0.
  - Required response: cmd_valid in cycle 2 with cmd_idx=2; cmd_pulse=0x04 in cycles 3–6; busy low from cycle 8.
- Simultaneous requests:
  - req_pulse=0xFF in one cycle.
  - Required response: grants issued in order 0,1,…,7; eight pulses, each followed by a gap; pending reaches 0x00 after the last grant.
- Round-robin fairness:
  - After a grant to channel 5, pending=0x21.
  - Required response: channel 0 is served next, then channel 5.
- Backpressure:
  - Hold cmd_ready=0 for 10 cycles during ISSUE.
  - Required response: cmd_valid and cmd_idx stay stable and cmd_pulse stays 0; on cmd_ready=1, HOLD starts on the next cycle.
- Disable and re-queue:
  - enable=0 with req_pulse=0x03.
  - Required response: no cmd_valid and pending=0x03. After enable=1, channel 0 is granted.
  - Then repeat req_pulse[0] in the same cycle as its grant clear. Required response: pending[0] remains 1.
- Overflow (macro defined):
  - Pulse req_pulse[3] three times while pending[3]=1.
  - Required response: ovf_cnt=3; ovf_clr=1 then returns 0.
  - Force 0x10000 events. Required response: ovf_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/pulse_cmd_arbiter.sv
// rtl/pulse_cmd_arbiter.sv - round-robin pulse request arbiter with fixed-length one-hot command pulses
// Optional overflow counter enabled by defining PULSE_CMD_ARBITER_OVF_EN.
module pulse_cmd_arbiter #(
    parameter int SIZE      = 8,
    parameter int IDX_W     = 3,
    parameter int PULSE_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SIZE-1:0]  req_pulse,
    input  logic             enable,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [IDX_W-1:0] cmd_idx,
    output logic [SIZE-1:0]  cmd_pulse,
    output logic [SIZE-1:0]  pending,
    output logic             busy,
    input  logic             ovf_clr,
    output logic [15:0]      ovf_cnt
);

    localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, GAP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  cand;
    logic              grant;
    logic [SIZE-1:0]   clr_mask;
    logic [SIZE-1:0]   pending_nxt;

    // Walk downward so the candidate closest after last_grant is written last and wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = SIZE; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % SIZE);
            if (pending[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant     = 1'b0;
        cmd_valid = 1'b0;
        cmd_pulse = '0;
        case (state)
            IDLE: begin
                if (enable && (|pending)) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_W'(PULSE_LEN - 1);
                end
            end
            HOLD: begin
                cmd_pulse = SIZE'(1) << cmd_idx;
                if (cnt == '0) begin
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A new pulse arriving on the grant edge re-queues the channel.
    assign clr_mask    = grant ? (SIZE'(1) << winner) : '0;
    assign pending_nxt = (pending & ~clr_mask) | req_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cmd_idx    <= '0;
            last_grant <= IDX_W'(SIZE - 1);
            pending    <= '0;
            busy       <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            busy    <= (state_nxt != IDLE);
            if (grant) begin
                cmd_idx    <= winner;
                last_grant <= winner;
            end
        end
    end

`ifdef PULSE_CMD_ARBITER_OVF_EN
    logic ovf_event;

    assign ovf_event = |(req_pulse & pending & ~clr_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end else if (ovf_event && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign ovf_cnt        = '0;
`endif

endmodule
